// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding,
// default word width and an even-parity helper.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SERIAL_WIDTH_DFLT = 8;

    // Even parity of a word zero-extended to 32 bits.
    function automatic logic even_parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load, right-shifting register; bit 0 is the serial output bit.
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sr_q;

    // Next-state: load has priority over shift, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = sr_q >> 1;
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {WIDTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/serial_word_tx.sv
// Serialises WIDTH-bit words LSB first with a word-start marker.
// Optional macro SERIAL_WORD_TX_PARITY_EN appends an even-parity bit per frame.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DFLT
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_bit,
    output logic             ser_start,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WIDTH - 1);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ser_start_q;
    logic             busy_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic             par_q;
`endif

    logic             last_s;
    logic             ready_s;
    logic             accept_s;
    logic             sr_load_s;
    logic [WIDTH-1:0] sr_val_s;
    logic             sr_shift_s;

    // Handshake: ready depends only on state and counter; gated off in reset.
    always_comb begin
        last_s   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        if (!rst_n) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (state_q == IDLE) || last_s;
        end
        accept_s = ready_s && din_valid;
    end

    // Shift register control: load a new word, clear on return to idle,
    // otherwise advance one bit per cycle while shifting.
    always_comb begin
        sr_load_s  = 1'b0;
        sr_val_s   = {WIDTH{1'b0}};
        sr_shift_s = 1'b0;
        if (accept_s) begin
            sr_load_s = 1'b1;
            sr_val_s  = din;
        end else if (state_q == SHIFT) begin
            if (last_s) begin
                sr_load_s = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
            end else if (cnt_q == LAST_DATA_CNT) begin
                sr_load_s = 1'b1;
                sr_val_s  = WIDTH'(par_q);
`endif
            end else begin
                sr_shift_s = 1'b1;
            end
        end else begin
            sr_shift_s = 1'b0;
        end
    end

    ser_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk_i      (t_clk),
        .rst_n      (rst_n),
        .load_i     (sr_load_s),
        .load_val_i (sr_val_s),
        .shift_i    (sr_shift_s),
        .lsb_o      (ser_bit)
    );

    // Frame FSM, bit counter and registered status outputs.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            ser_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else if (accept_s) begin
            state_q     <= SHIFT;
            cnt_q       <= {CNT_W{1'b0}};
            ser_start_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q       <= even_parity32(32'(din));
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q       <= {CNT_W{1'b0}};
                    ser_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                SHIFT: begin
                    ser_start_q <= 1'b0;
                    if (last_s) begin
                        state_q <= IDLE;
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= {CNT_W{1'b0}};
                    ser_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = ready_s;
    assign ser_start = ser_start_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a frame-queue model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_serial_word_tx;

    localparam int W = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         t_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         ser_bit;
    logic         ser_start;
    logic         busy;

    serial_word_tx #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_bit   (ser_bit),
        .ser_start (ser_start),
        .busy      (busy)
    );

    always #5 t_clk = ~t_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of (bit, start) pairs still to appear; front = bit on the wire.
    typedef struct { logic b; logic s; } ent_t;
    ent_t fq[$];

    always @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
        end else begin : model_step
            logic acc;
            ent_t e;
            acc = din_valid && (fq.size() <= 1);
            if (fq.size() > 0) void'(fq.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    e.b = din[i];
                    e.s = (i == 0);
                    fq.push_back(e);
                end
`ifdef SERIAL_WORD_TX_PARITY_EN
                e.b = ^din;
                e.s = 1'b0;
                fq.push_back(e);
`endif
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge t_clk) begin
        if (fq.size() > 0) begin
            check("ser_bit", 32'(ser_bit), 32'(fq[0].b));
            check("ser_start", 32'(ser_start), 32'(fq[0].s));
            check("busy", 32'(busy), 32'd1);
        end else begin
            check("ser_bit_idle", 32'(ser_bit), 32'd0);
            check("ser_start_idle", 32'(ser_start), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end
        check("din_ready", 32'(din_ready), 32'(rst_n && (fq.size() <= 1)));
    end

    // Capture of the serial stream and a serial two's complementer fed by it.
    logic [31:0] cap;
    logic [31:0] comp;
    int          capn;
    logic        seen_one;

    always @(negedge t_clk) begin
        if (busy && capn < 32) begin
            if (ser_start) seen_one = 1'b0;
            cap[capn]  = ser_bit;
            comp[capn] = ser_bit ^ seen_one;
            seen_one   = seen_one | ser_bit;
            capn++;
        end
    end

    task automatic clear_cap();
        cap = '0;
        comp = '0;
        capn = 0;
        seen_one = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w);
        @(posedge t_clk); #1;
        clear_cap();
        din = w;
        din_valid = 1'b1;
        @(posedge t_clk); #1;
        din_valid = 1'b0;
        din = ~w;
        repeat (FL + 1) @(posedge t_clk);
        #1;
    endtask

    logic [W-1:0] vecs [4] = '{8'h5A, 8'hC3, 8'h00, 8'hFF};

    initial begin
        clear_cap();
        repeat (3) @(posedge t_clk);
        #1;
        check("rst_ready", 32'(din_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit", 32'(ser_bit), 32'd0);
        rst_n = 1'b1;

        // Single word accepted on the first edge after reset release.
        din = 8'hB6;
        din_valid = 1'b1;
        @(posedge t_clk); #1;
        din_valid = 1'b0;
        din = 8'h00;
        repeat (FL + 1) @(posedge t_clk);
        #1;
        check("b6_bits", 32'(cap[7:0]), 32'hB6);
        check("b6_len", 32'(capn), 32'(FL));

        foreach (vecs[k]) begin
            send(vecs[k]);
            check("vec_bits", 32'(cap[7:0]), 32'(vecs[k]));
            check("vec_len", 32'(capn), 32'(FL));
        end

        // Back-to-back frames with din_valid held high.
        @(posedge t_clk); #1;
        clear_cap();
        din = 8'h01;
        din_valid = 1'b1;
        @(posedge t_clk); #1;
        din = 8'h80;
        repeat (FL) @(posedge t_clk);
        #1;
        din_valid = 1'b0;
        repeat (FL + 2) @(posedge t_clk);
        #1;
`ifdef SERIAL_WORD_TX_PARITY_EN
        check("b2b_bits", cap, 32'h0003_0101);
`else
        check("b2b_bits", cap, 32'h0000_8001);
`endif
        check("b2b_len", 32'(capn), 32'(2 * FL));

        // Reset in the middle of a frame.
        @(posedge t_clk); #1;
        din = 8'hFF;
        din_valid = 1'b1;
        @(posedge t_clk); #1;
        din_valid = 1'b0;
        repeat (3) @(posedge t_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bit", 32'(ser_bit), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(din_ready), 32'd0);
        repeat (2) @(posedge t_clk);
        #1;
        rst_n = 1'b1;
        send(8'h0F);
        check("fresh_bits", 32'(cap[7:0]), 32'h0F);
        check("fresh_len", 32'(capn), 32'(FL));

        // Idle hold.
        clear_cap();
        din_valid = 1'b0;
        repeat (20) @(posedge t_clk);
        #1;
        check("idle_len", 32'(capn), 32'd0);
        check("idle_ready", 32'(din_ready), 32'd1);

`ifdef SERIAL_WORD_TX_PARITY_EN
        send(8'h07);
        check("par_bits", 32'(cap[8:0]), 32'h107);
        check("par_len", 32'(capn), 32'd9);
`endif

        // End-to-end through the serial two's complementer.
        send(8'h06);
        check("comp_bits", 32'(comp[7:0]), 32'hFA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per serial word (legal range 1..32).
REQ-002 Port: t_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: din  input  WIDTH  parallel word to send.
REQ-005 Port: din_valid  input  1  din holds a valid word.
REQ-006 Port: din_ready  output  1  block accepts din this cycle.
REQ-007 Port: ser_bit  output  1  serial data bit, LSB first; this is the serial complementer's data input i.
REQ-008 Port: ser_start  output  1  word-start marker, high during bit 0 only; this is the complementer's per-word reset r.
REQ-009 Port: busy  output  1  a frame is being shifted out.

Function
REQ-010 Two-state FSM, IDLE and SHIFT, shall be used.
REQ-011 A word shall be accepted on a rising edge where din_valid and din_ready are both high.
REQ-012 din_ready shall be high in IDLE, and in SHIFT during the last bit of a frame only; it shall be low otherwise.
REQ-013 Latency: on the edge that accepts a word, ser_bit shall become din[0] and ser_start shall become 1; both are visible in the following cycle.
REQ-014 Over the next WIDTH-1 cycles, ser_bit shall present din[1]..din[WIDTH-1], one bit per cycle, with ser_start held 0.
REQ-015 din shall be captured into an internal shift register at acceptance; later changes on din shall not affect the frame in flight.
REQ-016 Bit counter width shall be $clog2(WIDTH+1); the counter shall clear at acceptance and increment once per bit.
REQ-017 On the last bit: a handshake shall start the next frame on the following cycle with no gap (back-to-back); without a handshake the FSM shall return to IDLE.
REQ-018 In IDLE: ser_bit=0, ser_start=0, busy=0.
REQ-019 In SHIFT: busy=1.
REQ-020 WIDTH=1: every frame is a single bit with ser_start=1, and din_ready shall stay high while SHIFT is active.
REQ-021 All outputs except din_ready shall come from registers; din_ready shall be a function of state and counter only, never of din_valid.

Reset
REQ-022 While rst_n=0: state=IDLE, counter=0, shift register=0, ser_bit=0, ser_start=0, busy=0, din_ready=0.
REQ-023 Reset asserted mid-frame shall abort the frame immediately; the partial word shall not be resumed after release.
REQ-024 First acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro SERIAL_WORD_TX_PARITY_EN, when defined: after bit WIDTH-1, one extra cycle shall carry the even-parity bit (XOR of all data bits), making the frame WIDTH+1 cycles.
REQ-026 With the macro defined, the din_ready / back-to-back window of REQ-012 and REQ-017 shall move to the parity cycle.
REQ-027 With the macro undefined: frames are exactly WIDTH cycles and no parity logic is present.

Structure
REQ-028 Shared package serial_pkg shall hold the FSM state typedef (IDLE, SHIFT) and the default-width constant SERIAL_WIDTH_DFLT=8.
REQ-029 The shift register with parallel load shall be a sub-module, ser_shift_reg; the FSM, counter and handshake shall stay in serial_word_tx.

Verification
REQ-030 Single word: WIDTH=8, din=8'hB6 accepted -> ser_bit 0,1,1,0,1,1,0,1 over 8 cycles; ser_start=1 on the first cycle only; busy=1 for 8 cycles, then 0.
REQ-031 Back-to-back: 8'h01 then 8'h80 with din_valid held high -> 16 contiguous bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; ser_start on cycles 1 and 9.
REQ-032 Reset mid-frame: rst_n=0 after bit 3 of 8'hFF -> outputs 0 at once; after release, 8'h0F sends a complete, fresh frame.
REQ-033 Idle hold: din_valid=0 for 20 cycles -> ser_bit=0, ser_start=0, busy=0, din_ready=1 throughout.
REQ-034 Parity (macro defined): din=8'h07 -> 9-bit frame 1,1,1,0,0,0,0,0, then parity 1; din_ready high only on the 9th cycle.
REQ-035 End-to-end: output connected to the serial complementer, din=8'h06 -> complementer emits 0,1,0,1,1,1,1,1 (8'hFA).
